// File: rtl/piho_path_reader.sv
// piho_path_reader: drains path samples from BRAM to a valid/ready stream while accumulating sum x and sum x^2
module piho_path_reader #(
  parameter int unsigned path_N = 5,
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] bram_dout,
  output logic [31:0] bram_addr,
  output logic        bram_en,
  output logic [7:0]  bram_we,
  output logic        bram_rst,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] sum_x,
  output logic [63:0] sum_x2,
  output logic        busy,
  output logic        done
);
  localparam logic [15:0] LAST = 16'(path_N);
  localparam logic [1:0] WLEN = 2'(READ_LAT - 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] i_q, i_d, i_nx;
  logic [1:0] w_q, w_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic en_q, en_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [47:0] sx_q, sx_d;
  logic [63:0] sx2_q, sx2_d, x64;
  always_comb begin
    x64 = 64'(signed'(bram_dout[31:0]));
    i_nx = i_q + 16'd1;
    state_d = state_q;
    i_d = i_q;
    w_d = w_q;
    addr_d = addr_q;
    data_d = data_q;
    en_d = en_q;
    valid_d = valid_q;
    busy_d = busy_q;
    done_d = done_q;
    sx_d = sx_q;
    sx2_d = sx2_q;
    case (state_q)
      IDLE: if (start) begin
        sx_d = '0;
        sx2_d = '0;
        i_d = 16'd1;
        state_d = LAST == 16'd0 ? DONE : REQ;
        busy_d = LAST != 16'd0;
        done_d = LAST == 16'd0;
        en_d = LAST != 16'd0;
        addr_d = LAST == 16'd0 ? addr_q : 32'd8;
      end
      REQ: begin
        state_d = WAIT;
        w_d = WLEN;
      end
      WAIT: if (w_q == 2'd0) begin
        state_d = SEND;
        en_d = 1'b0;
        valid_d = 1'b1;
        data_d = bram_dout[31:0];
        sx_d = sx_q + x64[47:0];
        sx2_d = sx2_q + x64 * x64;
      end else w_d = w_q - 2'd1;
      SEND: if (out_ready) begin
        valid_d = 1'b0;
        if (i_q == LAST) begin
          state_d = DONE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          state_d = REQ;
          i_d = i_nx;
          en_d = 1'b1;
          addr_d = {13'd0, i_nx, 3'd0};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      w_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sx_q <= '0;
      sx2_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      w_q <= w_d;
      addr_q <= addr_d;
      data_q <= data_d;
      en_q <= en_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      sx_q <= sx_d;
      sx2_q <= sx2_d;
    end
  end
  assign bram_addr = addr_q;
  assign bram_en = en_q;
  assign bram_we = 8'h00;
  assign bram_rst = rst;
  assign out_data = data_q;
  assign out_valid = valid_q;
  assign sum_x = sx_q;
  assign sum_x2 = sx2_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_piho_path_reader.sv
// tb_piho_path_reader: randomized drains of two latency variants and an empty-path variant against a sequence-level model
module tb_piho_path_reader;
  localparam int N = 5;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rdy = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] mem [0:7];
  logic [31:0] addr [2], od [2], pd [2];
  logic en [2], brst [2], ov [2], bsy [2], dn [2];
  logic [7:0] we [2];
  logic [47:0] sx [2], esx [2];
  logic [63:0] sx2 [2], esx2 [2], dout [2];
  logic run [2], pv [2], prdy [2], preq [2], pdone [2];
  int t0 [2], k [2], h [2];
  int n_vec = 0, n_bad = 0, cyc = 0, mode = 0, st = 0;
  logic [31:0] zaddr, zod;
  logic zen, zbrst, zov, zbsy, zdn, zen_seen = 1'b0;
  logic [7:0] zwe;
  logic [47:0] zsx;
  logic [63:0] zsx2;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (zen) zen_seen = 1'b1;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  task automatic monitor(input int j);
    int rel;
    logic [31:0] x;
    longint xs;
    rel = cyc - t0[j];
    if (!rst) begin
      if (!run[j]) chk("idle_valid", 64'(ov[j]), 64'd0);
      else if (pdone[j]) begin
        chk("done_after_last", 64'(dn[j]), 64'd1);
        chk("busy_after_last", 64'(bsy[j]), 64'd0);
        run[j] = 1'b0;
        pdone[j] = 1'b0;
      end else begin
        if (preq[j]) begin
          chk("req_addr", 64'(addr[j]), 64'(8 * (k[j] + 1)));
          chk("req_en", 64'(en[j]), 64'd1);
          preq[j] = 1'b0;
        end
        if (pv[j] && !prdy[j]) begin
          chk("hold_valid", 64'(ov[j]), 64'd1);
          chk("hold_data", 64'(od[j]), 64'(pd[j]));
        end
        if (ov[j]) begin
          if (!pv[j]) chk("latency", 64'(rel), 64'(h[j] + 2 * j + 3));
          chk("send_addr", 64'(addr[j]), 64'(8 * (k[j] + 1)));
          chk("send_en", 64'(en[j]), 64'd0);
          if (rdy) begin
            x = mem[3'(k[j] + 1)];
            xs = longint'(signed'(x));
            esx[j] += 48'(xs);
            esx2[j] += 64'(xs * xs);
            chk("data", 64'(od[j]), 64'(x));
            chk("sum_x", 64'(sx[j]), 64'(esx[j]));
            chk("sum_x2", sx2[j], esx2[j]);
            k[j]++;
            h[j] = rel;
            if (k[j] == N) pdone[j] = 1'b1;
            else preq[j] = 1'b1;
          end
        end
        pv[j] = ov[j];
        prdy[j] = rdy;
        pd[j] = od[j];
      end
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : gl
    localparam int L = 2 * g + 1;
    logic [31:0] p [L];
    always @(posedge clk) begin
      if (en[g]) p[0] <= mem[addr[g][5:3]];
      for (int q = 1; q < L; q++) p[q] <= p[q - 1];
    end
    assign dout[g] = {~p[L - 1], p[L - 1]};
    piho_path_reader #(.path_N(N), .READ_LAT(L)) dut (
      .clk(clk), .rst(rst), .start(start), .bram_dout(dout[g]), .bram_addr(addr[g]),
      .bram_en(en[g]), .bram_we(we[g]), .bram_rst(brst[g]), .out_data(od[g]),
      .out_valid(ov[g]), .out_ready(rdy), .sum_x(sx[g]), .sum_x2(sx2[g]),
      .busy(bsy[g]), .done(dn[g])
    );
    always @(negedge clk) monitor(g);
  end
  piho_path_reader #(.path_N(0), .READ_LAT(1)) dut_z (
    .clk(clk), .rst(rst), .start(start), .bram_dout(64'd0), .bram_addr(zaddr),
    .bram_en(zen), .bram_we(zwe), .bram_rst(zbrst), .out_data(zod),
    .out_valid(zov), .out_ready(rdy), .sum_x(zsx), .sum_x2(zsx2),
    .busy(zbsy), .done(zdn)
  );
  initial forever begin
    @(posedge clk);
    #1;
    if (mode == 1) rdy = $urandom_range(0, 3) != 0;
    else rdy = !(mode == 2 && ov[0] && k[0] == 2 && st < 7);
    if (!rdy && mode == 2) st++;
  end
  task automatic check_reset();
    for (int j = 0; j < 2; j++) begin
      chk("rst_addr", 64'(addr[j]), 64'd0);
      chk("rst_en", 64'(en[j]), 64'd0);
      chk("rst_we", 64'(we[j]), 64'd0);
      chk("rst_bram_rst", 64'(brst[j]), 64'd1);
      chk("rst_data", 64'(od[j]), 64'd0);
      chk("rst_valid", 64'(ov[j]), 64'd0);
      chk("rst_sum_x", 64'(sx[j]), 64'd0);
      chk("rst_sum_x2", sx2[j], 64'd0);
      chk("rst_busy", 64'(bsy[j]), 64'd0);
      chk("rst_done", 64'(dn[j]), 64'd0);
      run[j] = 1'b0;
      pdone[j] = 1'b0;
      preq[j] = 1'b0;
    end
    chk("rst_z_done", 64'(zdn), 64'd0);
    chk("rst_z_addr", 64'(zaddr), 64'd0);
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    for (int j = 0; j < 2; j++) if (!run[j]) begin
      t0[j] = cyc - 1;
      run[j] = 1'b1;
      k[j] = 0;
      h[j] = 0;
      pv[j] = 1'b0;
      prdy[j] = 1'b0;
      preq[j] = 1'b1;
      pdone[j] = 1'b0;
      esx[j] = '0;
      esx2[j] = '0;
      st = 0;
      chk("start_done_clr", 64'(dn[j]), 64'd0);
      chk("start_busy", 64'(bsy[j]), 64'd1);
    end
    chk("z_done", 64'(zdn), 64'd1);
    chk("z_busy", 64'(zbsy), 64'd0);
  endtask
  task automatic wait_idle();
    for (int c = 0; c < 3000 && (run[0] || run[1]); c++) @(posedge clk);
    chk("drain_finished", 64'(run[0] | run[1]), 64'd0);
    run[0] = 1'b0;
    run[1] = 1'b0;
    repeat (3) @(posedge clk);
  endtask
  task automatic set_basic();
    mem[0] = 32'h0;
    mem[1] = 32'h0001_0000;
    mem[2] = 32'hFFFF_0000;
    mem[3] = 32'h0002_0000;
    mem[4] = 32'h0000_0000;
    mem[5] = 32'h0000_8000;
    mem[6] = 32'h0;
    mem[7] = 32'h0;
  endtask
  task automatic check_basic_sums();
    for (int j = 0; j < 2; j++) begin
      chk("basic_sum_x", 64'(sx[j]), 64'h0000_0002_8000);
      chk("basic_sum_x2", sx2[j], 64'h0000_0006_4000_0000);
    end
  endtask
  initial begin
    for (int j = 0; j < 2; j++) begin
      run[j] = 1'b0;
      pdone[j] = 1'b0;
      preq[j] = 1'b0;
      t0[j] = 0;
    end
    set_basic();
    repeat (3) @(posedge clk);
    #2 check_reset();
    rst = 1'b0;
    mode = 0;
    pulse_start();
    wait_idle();
    check_basic_sums();
    mode = 2;
    pulse_start();
    repeat (4) @(posedge clk);
    pulse_start();
    wait_idle();
    check_basic_sums();
    mode = 0;
    for (int i = 1; i <= N; i++) mem[i] = 32'h0;
    mem[1] = 32'h8000_0000;
    pulse_start();
    wait_idle();
    chk("min_sq_sum_x2", sx2[0], 64'h4000_0000_0000_0000);
    for (int i = 1; i <= N; i++) mem[i] = $urandom();
    pulse_start();
    for (int c = 0; c < 50 && !ov[0]; c++) begin
      @(posedge clk);
      #2;
    end
    chk("rst_while_valid", 64'(ov[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #2 check_reset();
    rst = 1'b0;
    pulse_start();
    wait_idle();
    mode = 1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 1; i <= N; i++) begin
        mem[i] = $urandom();
        if ($urandom_range(0, 3) == 0) mem[i] = 32'h8000_0000;
        else if ($urandom_range(0, 3) == 0) mem[i] = 32'h7FFF_FFFF;
      end
      pulse_start();
      wait_idle();
    end
    chk("z_never_enabled", 64'(zen_seen), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/piho_path_reader.md
# piho_path_reader

Read-back engine for the path-integral harmonic-oscillator core. Once the core signals completion, this block drains the stored path configuration from the shared 64-bit BRAM and streams each point to the host side over a valid/ready handshake. While draining, it accumulates Σx and Σx² so the host can form ⟨x⟩ and ⟨x²⟩ without re-reading memory. It is the read-side counterpart of the core's BRAM write port: the same address map, one sample per 64-bit word.

## Interface
- `path_N`, default 5: number of path points stored at byte addresses 8·1 … 8·path_N (address 0 unused); legal range 0–65535.
- `READ_LAT`, default 1: BRAM read latency in cycles from address presented to `bram_dout` valid; legal 1–3.
- `clk` in 1: sole clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a drain; sampled only in IDLE.
- `bram_dout` in 64: BRAM read data; bits [31:0] are a signed Q16.16 sample x, bits [63:32] are ignored.
- `bram_addr` out 32: BRAM byte address.
- `bram_en` out 1: BRAM enable.
- `bram_we` out 8: tied to 8'h00; this block never writes.
- `bram_rst` out 1: equal to `rst`.
- `out_data` out 32: current sample x.
- `out_valid` out 1: `out_data` holds a sample.
- `out_ready` in 1: consumer accepts the sample.
- `sum_x` out 48: signed running Σx, Q32.16.
- `sum_x2` out 64: unsigned running Σx², Q32.32.
- `busy` out 1: drain in progress.
- `done` out 1: drain complete; held until the next accepted `start` or `rst`.

## Operation
- States: IDLE, REQ, WAIT, SEND, DONE. Point index `i` counts from 1 to path_N.
- **IDLE**
  - If `start`=1, clear `sum_x`, `sum_x2` and `done`, set `i`=1, set `busy`=1.
  - Go to REQ, or go directly to DONE if path_N=0. No BRAM access occurs when path_N=0.
- **REQ** (1 cycle): drive `bram_addr`=8·i and `bram_en`=1, then go to WAIT.
- **WAIT** (READ_LAT cycles)
  - In the last WAIT cycle, register `bram_dout[31:0]` into `out_data`.
  - In the same edge: add the sign-extended x to `sum_x`, and add x·x (signed 32×32, 64-bit result) to `sum_x2`.
  - Go to SEND.
- **SEND**
  - Hold `out_valid`=1 and keep `out_data` stable until `out_ready`=1.
  - On handshake: if i=path_N, go to DONE; otherwise i←i+1 and go to REQ.
- **DONE**: `busy`=0, `done`=1, go to IDLE. `done` stays high while in IDLE.
- `bram_en` is 1 only in REQ and WAIT. `bram_addr` holds its last value elsewhere.
- Both accumulators wrap modulo 2^width with no saturation.
- `start` while `busy`=1 is ignored.
- `rst` at any time, including mid-drain or mid-handshake, returns the block to IDLE within one cycle. The drain is not resumed.

## Timing
- Reset values: `bram_addr`=0, `bram_en`=0, `bram_we`=0, `out_data`=0, `out_valid`=0, `sum_x`=0, `sum_x2`=0, `busy`=0, `done`=0.
- With `start` sampled in cycle 0:
  - `bram_addr`=8 and `bram_en`=1 in cycle 1.
  - First `out_valid` in cycle 2+READ_LAT.
- With `out_ready` held at 1:
  - One sample is produced every READ_LAT+2 cycles.
  - The next REQ follows the handshake cycle directly.
- Accumulators update in the same edge that raises `out_valid`. They already include the presented sample while it is offered.
- After the last handshake in cycle t, `busy`=0 and `done`=1 in cycle t+1.
- `out_ready` asserted outside SEND has no effect.
- `out_valid` never drops without a handshake, except on `rst`.

## Test plan
- **Basic drain.** Preload words 1..5 with x = 0x00010000, 0xFFFF0000, 0x00020000, 0, 0x00008000; pulse `start`; hold `out_ready`=1.
  - Response: exactly 5 samples, in that order.
  - `sum_x`=0x0000_0002_8000; `sum_x2`=0x0000_0006_4000_0000.
  - `done`=1 exactly 1 cycle after the 5th handshake.
- **Latency.** With READ_LAT=1, `start` in cycle 0.
  - Response: `bram_addr`=8 in cycle 1, `out_valid` in cycle 3, `bram_addr`=16 in cycle 4.
  - Repeat with READ_LAT=3: first `out_valid` in cycle 5.
- **Back-pressure.** Hold `out_ready`=0 for 7 cycles on sample 3.
  - Response: `out_valid` and `out_data` stay stable throughout.
  - No new BRAM address is issued.
  - The sample sequence and sums are unchanged from the basic drain.
- **Ignored start and re-run.** Pulse `start` mid-drain: it is ignored. After `done`, pulse `start` again.
  - Response: `done` clears the next cycle.
  - Sums restart from 0 and end with the same values as the first run.
- **Reset mid-handshake.** Assert `rst` while `out_valid`=1.
  - Response: all outputs return to their reset values the next cycle.
  - A following `start` begins again at address 8.
- **Edge cases.**
  - path_N=0: `done`=1 one cycle after `start`, and `bram_en` is never asserted.
  - x=0x80000000: `sum_x2` gains 0x4000_0000_0000_0000.
